m_axi_lite_master: RTL and testbench

// - AXI4-Lite master: turns single read/write commands from a simple valid/ready command port into AXI4-Lite transactions.
// - Returns each result on a held response port.
// - Drives the register-file slaves and AXI-Lite peripherals in the design from local control FSMs or debug/UART bridges.
// - One transaction outstanding at a time, no pipelining.

---
 rtl/m_axi_lite_master.sv | 274 +++++++++++++++++++++++++++
 tb/tb_m_axi_lite_master.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi_lite_master.sv
// AXI4-Lite master: one read or write command in, one held response out, one transaction in flight.
// Optional watchdog for hung slaves is compiled in with `define M_AXI_LITE_TIMEOUT_EN.
module m_axi_lite_master #(
  parameter int ADDR_WIDTH       = 6,
  parameter int DATA_WIDTH       = 32,
  parameter int DATA_BYTES_COUNT = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        aclk,
  input  logic                        areset,
  // command port
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr,
  input  logic [DATA_WIDTH-1:0]       cmd_wdata,
  input  logic [DATA_BYTES_COUNT-1:0] cmd_wstrb,
  // response port
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  // AXI4-Lite master
  output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [DATA_WIDTH-1:0]       m_axi_wdata,
  output logic [DATA_BYTES_COUNT-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  if ((DATA_WIDTH != 32) && (DATA_WIDTH != 64)) begin : g_bad_data_width
    $error("m_axi_lite_master: DATA_WIDTH must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("m_axi_lite_master: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_DATA,
    S_RSP
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
  logic [DATA_BYTES_COUNT-1:0] wstrb_q, wstrb_d;
  logic                        awvalid_q, awvalid_d;
  logic                        wvalid_q, wvalid_d;
  logic                        bready_q, bready_d;
  logic                        arvalid_q, arvalid_d;
  logic                        rready_q, rready_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                  rsp_resp_q, rsp_resp_d;
  logic                        aw_fire, w_fire;

`ifdef M_AXI_LITE_TIMEOUT_EN
  localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               busy;

  assign busy        = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                       (state_q == S_RD_REQ) || (state_q == S_RD_DATA);
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign aw_fire = awvalid_q && m_axi_awready;
  assign w_fire  = wvalid_q && m_axi_wready;

  always_comb begin
    // NOTE: every next-state variable gets its default first, so no branch can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            state_d   = S_WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = S_RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_REQ: begin
        // AW and W complete independently; either order (or together) moves on.
        if (aw_fire) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_fire) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d   = S_WR_RESP;
          bready_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      S_WR_RESP: begin
        if (bready_q && m_axi_bvalid) begin
          state_d     = S_RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
        end
      end
      S_RD_REQ: begin
        if (arvalid_q && m_axi_arready) begin
          state_d   = S_RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (rready_q && m_axi_rvalid) begin
          state_d     = S_RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef M_AXI_LITE_TIMEOUT_EN
    timer_d       = '0;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == S_RSP && rsp_ready) begin
      rsp_timeout_d = 1'b0;
    end
    if (busy) begin
      // The watchdog wins over a handshake landing in the same cycle.
      if (timer_q == TIMER_LAST) begin
        state_d       = S_RSP;
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        aw_done_d     = 1'b0;
        w_done_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = 2'b11;
        rsp_timeout_d = 1'b1;
      end else if (state_d == state_q) begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      // NOTE: non-blocking updates so every register samples the same pre-edge values.
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

`ifdef M_AXI_LITE_TIMEOUT_EN
  always_ff @(posedge aclk) begin
    if (areset) begin
      timer_q       <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
`endif

  assign cmd_ready     = (state_q == S_IDLE) && !areset;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_m_axi_lite_master.sv
// Self-checking bench for m_axi_lite_master: behavioural AXI-Lite slave with programmable
// latencies and responses, a word-array reference model, and directed plus random commands.
`timescale 1ns/1ps
module tb_m_axi_lite_master;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [SW-1:0] m_axi_wstrb;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rvalid, m_axi_rready;

  m_axi_lite_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_BYTES_COUNT(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration, written only by the stimulus process.
  int       aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  bit       ar_never = 1'b0;

  // Slave-side observations, written only by the slave process.
  logic [31:0]   s_mem [16];
  logic [AW-1:0] aw_addr_seen, ar_addr_seen, r_addr;
  logic [DW-1:0] w_data_seen;
  logic [SW-1:0] w_strb_seen;
  int  b_hs_cnt = 0, viol = 0;
  bit  aw_got, w_got, b_pend, r_pend;
  int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic          p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic [SW-1:0] p_wstrb;

  // Slave decides its outputs on the falling edge; a handshake happens on the next rising edge
  // exactly when the freshly chosen ready/valid meets the master's registered valid/ready.
  always @(negedge aclk) begin
    if (areset) begin
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
      m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr} = '0;
      p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
      r_addr = '0;
      for (int i = 0; i < 16; i++) s_mem[i] = '0;
    end else begin
      if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
      if (p_awv && p_awr && m_axi_awvalid) viol++;
      if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wstrb != p_wstrb)) viol++;
      if (p_wv && p_wr && m_axi_wvalid) viol++;
      if (!ar_never && p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
      if (p_arv && p_arr && m_axi_arvalid) viol++;
      if (p_bv && p_br && m_axi_bready) viol++;
      if (p_rv && p_rr && m_axi_rready) viol++;
      if (m_axi_awprot != 3'b000 || m_axi_arprot != 3'b000) viol++;

      m_axi_bvalid = b_pend && (b_cnt >= b_lat);
      if (b_pend && !m_axi_bvalid) b_cnt++;
      m_axi_bresp = cfg_bresp;
      if (m_axi_bvalid && m_axi_bready) begin
        b_hs_cnt++;
        b_pend = 0;
      end

      m_axi_rvalid = r_pend && (r_cnt >= r_lat);
      if (r_pend && !m_axi_rvalid) r_cnt++;
      m_axi_rdata = s_mem[r_addr[5:2]];
      m_axi_rresp = cfg_rresp;
      if (m_axi_rvalid && m_axi_rready) r_pend = 0;

      // Ready only once both AW and W are presented, to exercise the both-valids slave.
      m_axi_awready = 1'b0;
      if (m_axi_awvalid && !aw_got && (m_axi_wvalid || w_got)) begin
        if (aw_cnt >= aw_lat) begin
          m_axi_awready = 1'b1;
          aw_got = 1;
          aw_addr_seen = m_axi_awaddr;
        end else aw_cnt++;
      end
      m_axi_wready = 1'b0;
      if (m_axi_wvalid && !w_got && (m_axi_awvalid || aw_got)) begin
        if (w_cnt >= w_lat) begin
          m_axi_wready = 1'b1;
          w_got = 1;
          w_data_seen = m_axi_wdata;
          w_strb_seen = m_axi_wstrb;
        end else w_cnt++;
      end
      if (aw_got && w_got) begin
        for (int b = 0; b < SW; b++)
          if (w_strb_seen[b]) s_mem[aw_addr_seen[5:2]][8*b +: 8] = w_data_seen[8*b +: 8];
        b_pend = 1; b_cnt = 0;
        aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
      end

      m_axi_arready = 1'b0;
      if (m_axi_arvalid && !r_pend && !ar_never) begin
        if (ar_cnt >= ar_lat) begin
          m_axi_arready = 1'b1;
          ar_addr_seen = m_axi_araddr;
          r_addr = m_axi_araddr;
          r_pend = 1; r_cnt = 0; ar_cnt = 0;
        end else ar_cnt++;
      end

      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
      p_bv = m_axi_bvalid; p_br = m_axi_bready; p_rv = m_axi_rvalid; p_rr = m_axi_rready;
    end
  end

  // Reference model: the slave's word array as the command stream should leave it.
  logic [31:0] ref_mem [16];

  task automatic ref_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [SW-1:0] ws);
    int w;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
    w = 0;
    while (!cmd_ready && w < 20) begin
      tick();
      w++;
    end
    check("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
    cmd_wstrb = SW'($urandom);
    cmd_addr  = AW'($urandom);
  endtask

  task automatic collect(input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp,
                         input bit exp_to, input int hold, output int lat,
                         output logic [1:0] snap);
    lat = 1;
    snap = 2'b00;
    while (!rsp_valid && lat < 300) begin
      if (lat == 2) snap = {m_axi_awvalid, m_axi_wvalid};
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_wait", rsp_valid, 1);
      return;
    end
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_resp", rsp_resp, exp_resp);
    check("rsp_timeout", rsp_timeout, exp_to);
    check("rsp_axi_idle", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = 1'b0;
      check("hold_valid", rsp_valid, 1);
      check("hold_resp", rsp_resp, exp_resp);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_cmd_ready", cmd_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_clear", rsp_valid, 0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [SW-1:0] ws, input int hold, output int lat,
                          output logic [1:0] snap);
    int b_before;
    b_before = b_hs_cnt;
    issue(1'b1, addr, wd, ws);
    collect('0, cfg_bresp, 1'b0, hold, lat, snap);
    check("awaddr", aw_addr_seen, addr);
    check("wdata", w_data_seen, wd);
    check("wstrb", w_strb_seen, ws);
    check("b_handshakes", b_hs_cnt - b_before, 1);
    for (int b = 0; b < SW; b++)
      if (ws[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int hold, output int lat);
    logic [1:0] snap;
    issue(1'b0, addr, $urandom, SW'($urandom));
    collect(ref_mem[addr[5:2]], cfg_rresp, 1'b0, hold, lat, snap);
    check("araddr", ar_addr_seen, addr);
  endtask

  int lat;
  logic [1:0] snap;

  initial begin
    areset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    ref_clear();
    tick();
    tick();
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                           m_axi_rready, rsp_valid}, 0);
    check("reset_rsp", {rsp_rdata, rsp_resp, rsp_timeout}, 0);
    areset = 1'b0;
    tick();
    check("idle_cmd_ready", cmd_ready, 1);

    // Zero-wait slave with one-cycle B turnaround: response four cycles after acceptance.
    b_lat = 1;
    do_write(6'h08, 32'hDEAD_BEEF, 4'hF, 0, lat, snap);
    check("write_latency", lat, 4);
    b_lat = 0;
    do_read(6'h08, 0, lat);
    do_write(6'h08, 32'h0000_1234, 4'b0011, 1, lat, snap);
    do_read(6'h08, 0, lat);

    // W accepted three cycles after AW.
    aw_lat = 0; w_lat = 3;
    do_write(6'h14, 32'hCAFE_F00D, 4'hF, 0, lat, snap);
    check("aw_drop_w_hold", snap, 2'b01);
    w_lat = 0;

    // SLVERR read with the response held off for five cycles.
    cfg_rresp = 2'b10;
    do_read(6'h08, 5, lat);
    cfg_rresp = 2'b00;

    // Reset while waiting for BVALID abandons the write.
    b_lat = 10;
    issue(1'b1, 6'h10, 32'h5555_AAAA, 4'hF);
    for (int w = 0; w < 20 && !m_axi_bready; w++) tick();
    check("reach_wr_resp", m_axi_bready, 1);
    areset = 1'b1;
    tick();
    check("midrst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                            m_axi_rready, rsp_valid}, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    areset = 1'b0;
    b_lat = 0;
    ref_clear();
    tick();
    do_read(6'h10, 0, lat);

    for (int n = 0; n < 40; n++) begin
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      b_lat  = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
      r_lat  = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom_range(0, 3));
      cfg_rresp = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom), $urandom, SW'($urandom), $urandom_range(0, 3), lat, snap);
      else
        do_read(AW'($urandom), $urandom_range(0, 3), lat);
    end
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;

`ifdef M_AXI_LITE_TIMEOUT_EN
    ar_nver_block: begin
      ar_never = 1'b1;
      issue(1'b0, 6'h04, '0, '0);
      collect('0, 2'b11, 1'b1, 0, lat, snap);
      check("timeout_latency", lat, TO + 1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      ar_never = 1'b0;
      ref_clear();
      tick();
    end
`endif

    check("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
